// File: rtl/divclk_monitor_if.sv
// ============================================================================
// Module   : divclk_monitor_if
// Purpose  : Control and measurement bundle between a divided-clock source
//            and divclk_monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface divclk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_in;
  logic             fault_clr;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             fault;

  modport master (
    output en, div_in, fault_clr,
    input  rise_pulse, fall_pulse, period, high_time, period_valid, locked, fault
  );

  modport slave (
    input  en, div_in, fault_clr,
    output rise_pulse, fall_pulse, period, high_time, period_valid, locked, fault
  );
endinterface

`default_nettype wire

// File: rtl/divclk_monitor.sv
// ============================================================================
// Module   : divclk_monitor
// Purpose  : Edge strobes, period/high-time measurement, lock and sticky fault
//            for a divided clock sampled in the clk domain.
//            Optional duty-cycle qualification: DIVCLK_DUTY_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module divclk_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  divclk_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_MEASURE = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam int                 c_MATCH_W    = $clog2(LOCK_CNT + 1);
  localparam int                 c_DW         = CNT_W + 2;
  localparam logic [CNT_W-1:0]   c_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
  localparam logic [c_MATCH_W-1:0] c_MATCH_ONE  = c_MATCH_W'(1);
  localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
  localparam logic [c_DW-1:0]    c_EXP        = c_DW'(EXP_PERIOD);
  localparam logic [c_DW-1:0]    c_TOL        = c_DW'(TOL);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_div_q;
  logic [CNT_W-1:0]      r_cnt;
  logic [c_MATCH_W-1:0]  r_match_cnt;
  logic                  r_rise_pulse;
  logic                  r_fall_pulse;
  logic [CNT_W-1:0]      r_period;
  logic [CNT_W-1:0]      r_high_time;
  logic                  r_period_valid;
  logic                  r_locked;
  logic                  r_fault;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_cnt_sat;
  logic                  w_active;
  logic                  w_in_tol;
  logic                  w_measure;
  logic                  w_lock_set;
  logic                  w_lock_clr;
  logic                  w_match_inc;
  logic                  w_match_clr;
  logic                  w_fault_set;
  logic [c_DW-1:0]       w_cnt_x;
  logic [c_DW-1:0]       w_per_dev;
  logic                  w_per_ok;

  assign w_rise    = mon.div_in & ~r_div_q;
  assign w_fall    = ~mon.div_in & r_div_q;
  assign w_cnt_sat = (r_cnt == c_CNT_MAX);
  assign w_active  = (r_state == S_MEASURE) || (r_state == S_LOCKED);

  // The period under test is the count accumulated since the previous rise.
  assign w_cnt_x   = c_DW'(r_cnt);
  assign w_per_dev = (w_cnt_x >= c_EXP) ? (w_cnt_x - c_EXP) : (c_EXP - w_cnt_x);
  assign w_per_ok  = (w_per_dev <= c_TOL);

`ifdef DIVCLK_DUTY_CHECK_EN
  localparam logic [c_DW-1:0] c_TOL2 = c_DW'(2 * TOL);
  logic [c_DW-1:0] w_ht2;
  logic [c_DW-1:0] w_duty_dev;

  assign w_ht2      = {1'b0, r_high_time, 1'b0};
  assign w_duty_dev = (w_ht2 >= w_cnt_x) ? (w_ht2 - w_cnt_x) : (w_cnt_x - w_ht2);
  assign w_in_tol   = w_per_ok & (w_duty_dev <= c_TOL2);
`else
  assign w_in_tol   = w_per_ok;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_measure   = 1'b0;
    w_lock_set  = 1'b0;
    w_lock_clr  = 1'b0;
    w_match_inc = 1'b0;
    w_match_clr = 1'b0;
    w_fault_set = 1'b0;
    if (!mon.en) begin
      w_state_nxt = S_IDLE;
      w_lock_clr  = 1'b1;
      w_match_clr = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ACQUIRE;
        S_ACQUIRE: begin
          if (w_rise) w_state_nxt = S_MEASURE;
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_measure = 1'b1;
            if (w_in_tol) begin
              w_match_inc = 1'b1;
              if (r_match_cnt == c_MATCH_LAST) begin
                w_state_nxt = S_LOCKED;
                w_lock_set  = 1'b1;
              end
            end else begin
              w_match_clr = 1'b1;
            end
          end else if (w_cnt_sat) begin
            w_fault_set = 1'b1;
            w_lock_clr  = 1'b1;
            w_match_clr = 1'b1;
            w_state_nxt = S_ACQUIRE;
          end
        end
        S_LOCKED: begin
          if (w_rise) begin
            w_measure = 1'b1;
            if (!w_in_tol) begin
              w_fault_set = 1'b1;
              w_lock_clr  = 1'b1;
              w_match_clr = 1'b1;
              w_state_nxt = S_MEASURE;
            end
          end else if (w_cnt_sat) begin
            w_fault_set = 1'b1;
            w_lock_clr  = 1'b1;
            w_match_clr = 1'b1;
            w_state_nxt = S_ACQUIRE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_q        <= 1'b0;
      r_cnt          <= '0;
      r_match_cnt    <= '0;
      r_rise_pulse   <= 1'b0;
      r_fall_pulse   <= 1'b0;
      r_period       <= '0;
      r_high_time    <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_div_q        <= mon.div_in;
      r_rise_pulse   <= mon.en & w_rise;
      r_fall_pulse   <= mon.en & w_fall;
      r_period_valid <= w_measure;

      if (!mon.en || (r_state == S_IDLE)) begin
        r_cnt <= '0;
      end else if (w_rise) begin
        r_cnt <= c_CNT_ONE;
      end else if (!w_cnt_sat) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end

      if (w_measure) r_period <= r_cnt;
      if (mon.en && w_active && w_fall) r_high_time <= r_cnt;

      if (w_match_clr) begin
        r_match_cnt <= '0;
      end else if (w_match_inc) begin
        r_match_cnt <= r_match_cnt + c_MATCH_ONE;
      end

      if (w_lock_set) begin
        r_locked <= 1'b1;
      end else if (w_lock_clr) begin
        r_locked <= 1'b0;
      end

      // A fault event in the same cycle as a clear request keeps the flag set.
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (mon.fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign mon.rise_pulse   = r_rise_pulse;
  assign mon.fall_pulse   = r_fall_pulse;
  assign mon.period       = r_period;
  assign mon.high_time    = r_high_time;
  assign mon.period_valid = r_period_valid;
  assign mon.locked       = r_locked;
  assign mon.fault        = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_divclk_monitor.sv
// ============================================================================
// Module   : tb_divclk_monitor
// Purpose  : Directed self-checking bench for divclk_monitor (EXP_PERIOD=4,
//            TOL=0, CNT_W=8, LOCK_CNT=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_divclk_monitor;

`ifdef DIVCLK_DUTY_CHECK_EN
  localparam bit c_DUTY = 1'b1;
`else
  localparam bit c_DUTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic       rp;
  logic       pv;
  logic       fp;
  logic [7:0] per;
  int         n_wait;

  always #5 clk = ~clk;

  divclk_monitor_if #(.CNT_W(8)) bus ();

  divclk_monitor #(
    .EXP_PERIOD (4),
    .TOL        (0),
    .CNT_W      (8),
    .LOCK_CNT   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One div_in period: hi cycles high then lo cycles low. Strobes sampled
  // right after the rising and falling edges are sampled.
  task automatic run_period(input int hi, input int lo, input bit clr,
                            output logic o_rp, output logic o_pv,
                            output logic [7:0] o_per, output logic o_fp);
    bus.div_in    = 1'b1;
    bus.fault_clr = clr;
    tick();
    o_rp  = bus.rise_pulse;
    o_pv  = bus.period_valid;
    o_per = bus.period;
    bus.fault_clr = 1'b0;
    for (int i = 1; i < hi; i++) tick();
    bus.div_in = 1'b0;
    tick();
    o_fp = bus.fall_pulse;
    for (int i = 1; i < lo; i++) tick();
  endtask

  task automatic run_n(input int hi, input int lo, input int n);
    logic a, b, d;
    logic [7:0] c;
    for (int k = 0; k < n; k++) run_period(hi, lo, 1'b0, a, b, c, d);
  endtask

  task automatic clr_pulse();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    bus.en        = 1'b1;
    bus.div_in    = 1'b0;
    bus.fault_clr = 1'b0;
    repeat (2) tick();
    chk_eq("rst_flags", {bus.rise_pulse, bus.fall_pulse, bus.period_valid, bus.locked, bus.fault}, 0);
    chk_eq("rst_period", bus.period, 0);
    chk_eq("rst_high", bus.high_time, 0);
    rst = 1'b1;
    tick();
    tick();

    // Divide-by-4 acquisition and lock
    run_period(2, 2, 1'b0, rp, pv, per, fp);
    chk_eq("t1_rise1", rp, 1);
    chk_eq("t1_pv1", pv, 0);
    chk_eq("t1_fall1", fp, 1);
    run_period(2, 2, 1'b0, rp, pv, per, fp);
    chk_eq("t1_pv2", pv, 1);
    chk_eq("t1_period", per, 4);
    chk_eq("t1_high", bus.high_time, 2);
    chk_eq("t1_rise_one_cycle", bus.rise_pulse, 0);
    run_n(2, 2, 2);
    chk_eq("t1_unlocked_rise4", bus.locked, 0);
    run_period(2, 2, 1'b0, rp, pv, per, fp);
    chk_eq("t1_locked_rise5", bus.locked, 1);
    chk_eq("t1_fault", bus.fault, 0);

    // Switch to divide-by-6 while locked
    run_period(3, 3, 1'b0, rp, pv, per, fp);
    chk_eq("t2_prev_period", per, 4);
    chk_eq("t2_still_locked", bus.locked, 1);
    run_period(3, 3, 1'b0, rp, pv, per, fp);
    chk_eq("t2_period6", per, 6);
    chk_eq("t2_fault", bus.fault, 1);
    chk_eq("t2_unlock", bus.locked, 0);
    run_n(3, 3, 3);
    chk_eq("t2_stays_unlocked", bus.locked, 0);
    chk_eq("t2_fault_sticky", bus.fault, 1);

    // Fault clear alone, then set-wins-over-clear
    clr_pulse();
    chk_eq("t4_clr_alone", bus.fault, 0);
    run_n(2, 2, 4);
    chk_eq("t4_not_yet_locked", bus.locked, 0);
    run_period(2, 2, 1'b0, rp, pv, per, fp);
    chk_eq("t4_relocked", bus.locked, 1);
    run_period(3, 3, 1'b0, rp, pv, per, fp);
    run_period(3, 3, 1'b1, rp, pv, per, fp);
    chk_eq("t4_set_wins", bus.fault, 1);
    chk_eq("t4_unlock", bus.locked, 0);
    clr_pulse();
    chk_eq("t4_clr_again", bus.fault, 0);

    // Stuck-low input after lock
    run_n(2, 2, 5);
    chk_eq("t3_locked", bus.locked, 1);
    n_wait = 0;
    while (!bus.fault && n_wait < 400) begin
      tick();
      n_wait++;
    end
    chk_eq("t3_stuck_delay", n_wait, 252);
    chk_eq("t3_unlock", bus.locked, 0);
    chk_eq("t3_cnt_sat", dut.r_cnt, 255);
    repeat (20) tick();
    chk_eq("t3_fault_held", bus.fault, 1);
    chk_eq("t3_cnt_held", dut.r_cnt, 255);
    run_n(2, 2, 4);
    chk_eq("t3_relock_pending", bus.locked, 0);
    run_period(2, 2, 1'b0, rp, pv, per, fp);
    chk_eq("t3_relocked", bus.locked, 1);
    chk_eq("t3_fault_kept", bus.fault, 1);

    // Enable dropped while locked
    bus.en = 1'b0;
    tick();
    chk_eq("t5_unlock", bus.locked, 0);
    chk_eq("t5_cnt_zero", dut.r_cnt, 0);
    chk_eq("t5_period_kept", bus.period, 4);
    chk_eq("t5_fault_kept", bus.fault, 1);
    bus.en = 1'b1;
    tick();
    run_n(2, 2, 4);
    chk_eq("t5_relock_pending", bus.locked, 0);
    run_period(2, 2, 1'b0, rp, pv, per, fp);
    chk_eq("t5_relocked", bus.locked, 1);

    // Asynchronous reset with a rise strobe in flight
    bus.div_in = 1'b1;
    tick();
    chk_eq("t6_rise_before_rst", bus.rise_pulse, 1);
    #2 rst = 1'b0;
    #1;
    chk_eq("t6_rst_flags", {bus.rise_pulse, bus.fall_pulse, bus.period_valid, bus.locked, bus.fault}, 0);
    chk_eq("t6_rst_period", bus.period, 0);
    chk_eq("t6_rst_high", bus.high_time, 0);
    #1 rst = 1'b1;
    bus.div_in = 1'b0;
    tick();
    tick();

    // 3-high/1-low period-4 input: duty qualification decides lock
    run_n(3, 1, 4);
    run_period(3, 1, 1'b0, rp, pv, per, fp);
    chk_eq("t6_duty_period", per, 4);
    chk_eq("t6_duty_high", bus.high_time, 3);
    chk_eq("t6_duty_lock", bus.locked, c_DUTY ? 0 : 1);
    run_n(2, 2, 5);
    chk_eq("t6_lock_50pct", bus.locked, 1);
    run_n(3, 1, 2);
    chk_eq("t6_duty_fault", bus.fault, c_DUTY ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
